// File: rtl/led_pkg.sv
// Shared definitions for the LED scheduler: mode codes, FSM states and pattern helpers.
package led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [LED_W-1:0] load_pattern(input mode_t mode);
        case (mode)
            MODE_FLASH: load_pattern = 4'b1111;
            MODE_RUN:   load_pattern = 4'b0001;
            MODE_SOLID: load_pattern = 4'b1111;
            default:    load_pattern = 4'b0000;
        endcase
    endfunction

    // Single pattern step applied on each tick; OFF and SOLID are static.
    function automatic logic [LED_W-1:0] step_pattern(input mode_t mode,
                                                      input logic [LED_W-1:0] pat);
        case (mode)
            MODE_FLASH: step_pattern = ~pat;
            MODE_RUN:   step_pattern = {pat[LED_W-2:0], pat[LED_W-1]};
            default:    step_pattern = pat;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ/TICK_HZ clocks.
module led_tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 10
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (clr || tick_cnt == LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/led_sched_ctrl.sv
// Fixed-priority LED bank scheduler with minimum dwell before preemption.
module led_sched_ctrl
    import led_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 10,
    parameter int HOLD_TICKS = 20,
    parameter int N_REQ      = 3
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_mode,
    output logic [LED_W-1:0]   led,
    output logic [N_REQ-1:0]   grant,
    output logic               active
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DWELL_W = $clog2(HOLD_TICKS + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(HOLD_TICKS);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [IDX_W-1:0]   load_idx;
    logic               load;
    mode_t              mode_q;
    mode_t              new_mode;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_done;
    logic               tick;

    // Lowest set index wins; scanning downward leaves the smallest index last.
    always_comb begin
        arb_idx = '0;
        arb_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                arb_idx = IDX_W'(i);
                arb_any = 1'b1;
            end
        end
    end

    assign dwell_done = (dwell_cnt == DWELL_MAX);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = arb_idx;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (!req[owner]) begin
                    if (arb_any) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (arb_idx < owner && dwell_done) begin
                    load = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign new_mode = mode_t'(req_mode[{load_idx, 1'b0} +: 2]);

    // A switch in the same cycle as a tick takes precedence: reload, no step.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            grant     <= '0;
            mode_q    <= MODE_OFF;
            led       <= '0;
            dwell_cnt <= '0;
        end else if (load) begin
            owner     <= load_idx;
            grant     <= N_REQ'(1) << load_idx;
            mode_q    <= new_mode;
            led       <= load_pattern(new_mode);
            dwell_cnt <= '0;
        end else if (state_nxt == ST_IDLE) begin
            grant     <= '0;
            led       <= '0;
            dwell_cnt <= '0;
        end else if (tick) begin
            led <= step_pattern(mode_q, led);
            if (!dwell_done) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    assign active = (state == ST_RUN);

    led_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr     (load || state != ST_RUN),
        .tick    (tick)
    );

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Directed bench for led_sched_ctrl with a 10-cycle tick and 3-tick dwell.
module tb_led_sched_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [5:0] req_mode;
    logic [3:0] led;
    logic [2:0] grant;
    logic       active;

    int checks = 0;
    int errors = 0;

    led_sched_ctrl #(
        .CLK_FREQ   (100),
        .TICK_HZ    (10),
        .HOLD_TICKS (3),
        .N_REQ      (3)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_mode (req_mode),
        .led      (led),
        .grant    (grant),
        .active   (active)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_led,
                             input logic [2:0] e_grant, input logic e_active);
        check({tag, ".led"},    {4'b0, led},    {4'b0, e_led});
        check({tag, ".grant"},  {5'b0, grant},  {5'b0, e_grant});
        check({tag, ".active"}, {7'b0, active}, {7'b0, e_active});
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 3'b000;
        req_mode = 6'b0;
        step(2);
        check_all("reset", 4'b0000, 3'b000, 1'b0);
        rst_n = 1'b1;
        step(2);
        check_all("idle", 4'b0000, 3'b000, 1'b0);

        // FLASH with a mid-run mode change that must be ignored
        req_mode = 6'b00_00_01;
        req      = 3'b001;
        step(1);
        check_all("flash_grant", 4'b1111, 3'b001, 1'b1);
        step(9);
        check("flash_c9", {4'b0, led}, 8'h0f);
        step(1);
        check("flash_c10", {4'b0, led}, 8'h00);
        req_mode = 6'b00_00_11;
        step(10);
        check("flash_c20", {4'b0, led}, 8'h0f);
        step(10);
        check("flash_c30", {4'b0, led}, 8'h00);

        req = 3'b000;
        step(1);
        check_all("drop_idle", 4'b0000, 3'b000, 1'b0);

        // RUN rotation
        req_mode = 6'b00_00_10;
        req      = 3'b001;
        step(1);
        check_all("run_load", 4'b0001, 3'b001, 1'b1);
        step(10);
        check("run_s1", {4'b0, led}, 8'h02);
        step(10);
        check("run_s2", {4'b0, led}, 8'h04);
        step(10);
        check("run_s3", {4'b0, led}, 8'h08);
        step(10);
        check("run_wrap", {4'b0, led}, 8'h01);
        step(20);
        check("run_pre_rst", {4'b0, led}, 8'h04);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 3'b000, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        step(1);
        check_all("post_rst", 4'b0001, 3'b001, 1'b1);
        req = 3'b000;
        step(1);
        check_all("idle2", 4'b0000, 3'b000, 1'b0);

        // Dwell-limited preemption: mode0 FLASH, mode1 RUN, mode2 RUN
        req_mode = 6'b10_10_01;
        req      = 3'b100;
        step(1);
        check_all("low_grant", 4'b0001, 3'b100, 1'b1);
        step(4);
        req = 3'b101;
        step(1);
        check("hold_c5", {5'b0, grant}, 8'h04);
        step(24);
        check("hold_c29", {5'b0, grant}, 8'h04);
        step(1);
        check("hold_c30.grant", {5'b0, grant}, 8'h04);
        check("hold_c30.led", {4'b0, led}, 8'h08);
        step(1);
        check_all("preempt", 4'b1111, 3'b001, 1'b1);

        req = 3'b011;
        step(40);
        check("low_no_preempt", {5'b0, grant}, 8'h01);

        // Owner drops with req1 pending: direct switch
        req = 3'b010;
        step(1);
        check_all("direct_switch", 4'b0001, 3'b010, 1'b1);

        req = 3'b000;
        step(1);
        check_all("idle3", 4'b0000, 3'b000, 1'b0);

        // OFF mode still grants but keeps LEDs dark
        req_mode = 6'b00_10_01;
        req      = 3'b100;
        step(1);
        check_all("off_grant", 4'b0000, 3'b100, 1'b1);
        step(10);
        check("off_hold", {4'b0, led}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
